key_debounce_pulse: RTL and testbench

KEY_DEBOUNCE_PULSE -- requirements
Module: key_debounce_pulse

---
 rtl/key_debounce_pulse.sv | 122 ++++++++++++
 tb/tb_key_debounce_pulse.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_pulse.sv
// Pushbutton debouncer: two-flop synchronizer, 4-state debounce FSM, one-cycle press strobe.
// Optional auto-repeat on a held key is enabled by defining KEY_AUTOREPEAT_EN.
module key_debounce_pulse #(
   parameter int unsigned DB_CYCLES  = 250000,
   parameter int unsigned RPT_DELAY  = 25000000,
   parameter int unsigned RPT_PERIOD = 5000000
) (
   input  logic       Clk,
   input  logic       Clr_n,
   input  logic       Key,
   output logic       Pulse,
   output logic       Level,
   output logic [1:0] State
);

   localparam int unsigned CW = $clog2(DB_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      RELEASED     = 2'b00,
      PRESS_WAIT   = 2'b01,
      PRESSED      = 2'b10,
      RELEASE_WAIT = 2'b11
   } state_t;

   // Zero-cycle debounce or repeat intervals have no meaning; refuse to elaborate them.
   if (DB_CYCLES < 1 || RPT_DELAY < 1 || RPT_PERIOD < 1) begin : g_bad_param
      $error("key_debounce_pulse: DB_CYCLES, RPT_DELAY and RPT_PERIOD must be 1 or greater");
   end

   state_t        state;
   logic          key_m;
   logic          key_s;
   logic [CW-1:0] cnt;

`ifdef KEY_AUTOREPEAT_EN
   localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_PERIOD) ? RPT_DELAY : RPT_PERIOD;
   localparam int unsigned RW      = $clog2(RPT_MAX + 1);

   logic [RW-1:0] rpt;
   logic          rpt_first;
   logic [RW-1:0] rpt_inc;
   logic [RW-1:0] rpt_target;

   // First repeat waits RPT_DELAY, every later one RPT_PERIOD; rpt restarts at each strobe.
   assign rpt_inc    = rpt + RW'(1);
   assign rpt_target = rpt_first ? RW'(RPT_DELAY) : RW'(RPT_PERIOD);
`endif

   always_ff @(posedge Clk or negedge Clr_n) begin
      if (!Clr_n) begin
         key_m     <= 1'b1;
         key_s     <= 1'b1;
         state     <= RELEASED;
         cnt       <= '0;
         Pulse     <= 1'b0;
         Level     <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
         rpt       <= '0;
         rpt_first <= 1'b1;
`endif
      end else begin
         key_m <= Key;
         key_s <= key_m;
         Pulse <= 1'b0;
         case (state)
            RELEASED: begin
               if (!key_s) begin
                  state <= PRESS_WAIT;
                  cnt   <= '0;
               end
            end
            PRESS_WAIT: begin
               if (key_s) begin
                  state <= RELEASED;
               end else if (cnt == CNT_LAST) begin
                  state <= PRESSED;
                  Level <= 1'b1;
                  Pulse <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                  rpt       <= '0;
                  rpt_first <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            PRESSED: begin
               if (key_s) begin
                  state <= RELEASE_WAIT;
                  cnt   <= '0;
               end else begin
`ifdef KEY_AUTOREPEAT_EN
                  if (rpt_inc == rpt_target) begin
                     Pulse     <= 1'b1;
                     rpt       <= '0;
                     rpt_first <= 1'b0;
                  end else begin
                     rpt <= rpt_inc;
                  end
`endif
               end
            end
            RELEASE_WAIT: begin
               // Repeat counter deliberately holds here so a release bounce resumes the schedule.
               if (!key_s) begin
                  state <= PRESSED;
               end else if (cnt == CNT_LAST) begin
                  state <= RELEASED;
                  Level <= 1'b0;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= RELEASED;
         endcase
      end
   end

   assign State = state;

endmodule

// File: tb/tb_key_debounce_pulse.sv
// Self-checking bench for key_debounce_pulse: run-length debounce model checked every cycle,
// plus directed scenarios with literal expectations. Honours KEY_AUTOREPEAT_EN like the DUT.
module tb_key_debounce_pulse;

   localparam int unsigned DB  = 4;
   localparam int unsigned RPD = 10;
   localparam int unsigned RPP = 5;

   logic       clk;
   logic       rst_n;
   logic       key;
   logic       Pulse;
   logic       Level;
   logic [1:0] State;

   int checks;
   int errors;

   key_debounce_pulse #(
      .DB_CYCLES (DB),
      .RPT_DELAY (RPD),
      .RPT_PERIOD(RPP)
   ) dut (
      .Clk  (clk),
      .Clr_n(rst_n),
      .Key  (key),
      .Pulse(Pulse),
      .Level(Level),
      .State(State)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic wait_edges(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Key value per edge taken from pat[e]; counts Pulse strobes seen.
   task automatic drive_seq(input logic [63:0] pat, input int n, output int pulses);
      pulses = 0;
      for (int e = 0; e < n; e++) begin
         @(negedge clk);
         key = pat[e];
         @(posedge clk);
         #1;
         if (Pulse === 1'b1) pulses++;
      end
   endtask

   // Model: the FSM sees Key two edges late; Level flips after DB+1 consecutive
   // disagreeing samples, and any agreeing sample restarts the run.
   initial begin : compare
      bit         kd1, kd2, rd, lvl, exp_pulse, stable;
      int         run, age;
      logic [1:0] exp_state;
      kd1 = 1'b1; kd2 = 1'b1; lvl = 1'b0; run = 0; age = 0;
      forever begin
         @(posedge clk);
         exp_pulse = 1'b0;
         if (!rst_n) begin
            kd1 = 1'b1; kd2 = 1'b1; lvl = 1'b0; run = 0; age = 0;
         end else begin
            rd     = kd2;
            kd2    = kd1;
            kd1    = key;
            stable = (run == 0);
            if ((!rd) != lvl) begin
               run++;
               if (run == int'(DB) + 1) begin
                  lvl = ~lvl;
                  run = 0;
                  if (lvl) begin
                     exp_pulse = 1'b1;
                     age       = 0;
                  end
               end
            end else begin
               run = 0;
`ifdef KEY_AUTOREPEAT_EN
               if (lvl && stable) begin
                  age++;
                  if (age == int'(RPD) ||
                      (age > int'(RPD) && ((age - int'(RPD)) % int'(RPP)) == 0))
                     exp_pulse = 1'b1;
               end
`endif
            end
         end
         exp_state = (run == 0) ? {lvl, 1'b0} : {lvl, 1'b1};
         #1;
         chk("model_pulse", 32'(Pulse), 32'(exp_pulse));
         chk("model_level", 32'(Level), 32'(lvl));
         chk("model_state", 32'(State), 32'(exp_state));
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation exceeded time limit, got running expected finished");
      $fatal(1);
   end

   initial begin : stim
      logic [63:0] pat;
      int          np;
      int          pe[$];
`ifdef KEY_AUTOREPEAT_EN
      int exp_e[8] = '{6, 16, 21, 26, 31, 36, 41, 46};
`else
      int exp_e[1] = '{6};
`endif
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      key    = 1'b1;
      wait_edges(3);
      chk("reset_pulse", 32'(Pulse), 32'd0);
      chk("reset_level", 32'(Level), 32'd0);
      chk("reset_state", 32'(State), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      repeat (5) @(negedge clk);

      // Clean press: strobe lands on edge DB+2 and lasts one cycle.
      key = 1'b0;
      wait_edges(6);
      chk("press_e5_pulse", 32'(Pulse), 32'd0);
      chk("press_e5_level", 32'(Level), 32'd0);
      chk("press_e5_state", 32'(State), 32'd1);
      wait_edges(1);
      chk("press_e6_pulse", 32'(Pulse), 32'd1);
      chk("press_e6_level", 32'(Level), 32'd1);
      chk("press_e6_state", 32'(State), 32'd2);
      wait_edges(1);
      chk("press_e7_pulse", 32'(Pulse), 32'd0);
      chk("press_e7_level", 32'(Level), 32'd1);
      repeat (13) @(negedge clk);
      key = 1'b1;
      wait_edges(6);
      chk("release_e5_level", 32'(Level), 32'd1);
      chk("release_e5_state", 32'(State), 32'd3);
      wait_edges(1);
      chk("release_e6_level", 32'(Level), 32'd0);
      chk("release_e6_state", 32'(State), 32'd0);
      chk("release_e6_pulse", 32'(Pulse), 32'd0);

      // Bounce rejection: low 3, high 2, low 3, then high.
      pat = '1;
      pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b0;
      pat[5] = 1'b0; pat[6] = 1'b0; pat[7] = 1'b0;
      drive_seq(pat, 20, np);
      chk("bounce_pulses", 32'(np), 32'd0);
      chk("bounce_level", 32'(Level), 32'd0);
      chk("bounce_state", 32'(State), 32'd0);

      // Release bounce: two high samples while pressed return to PRESSED.
      @(negedge clk) key = 1'b0;
      wait_edges(9);
      chk("rb_pressed_level", 32'(Level), 32'd1);
      @(negedge clk) key = 1'b1;
      wait_edges(1);
      @(negedge clk) key = 1'b1;
      wait_edges(1);
      @(negedge clk) key = 1'b0;
      wait_edges(1);
      chk("rb_e2_state", 32'(State), 32'd3);
      chk("rb_e2_level", 32'(Level), 32'd1);
      chk("rb_e2_pulse", 32'(Pulse), 32'd0);
      wait_edges(2);
      chk("rb_e4_state", 32'(State), 32'd2);
      chk("rb_e4_level", 32'(Level), 32'd1);
      chk("rb_e4_pulse", 32'(Pulse), 32'd0);
      @(negedge clk) key = 1'b1;
      wait_edges(10);
      chk("rb_final_level", 32'(Level), 32'd0);

      // Reset during PRESS_WAIT at count 2, key kept low throughout.
      @(negedge clk) key = 1'b0;
      wait_edges(5);
      chk("rst_mid_state_before", 32'(State), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_mid_pulse", 32'(Pulse), 32'd0);
      chk("rst_mid_level", 32'(Level), 32'd0);
      chk("rst_mid_state", 32'(State), 32'd0);
      @(negedge clk);
      @(negedge clk) rst_n = 1'b1;
      wait_edges(6);
      chk("rst_after_e5_pulse", 32'(Pulse), 32'd0);
      wait_edges(1);
      chk("rst_after_e6_pulse", 32'(Pulse), 32'd1);
      chk("rst_after_e6_level", 32'(Level), 32'd1);

      // Reset while pressed drops everything without a strobe.
      wait_edges(3);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_pressed_level", 32'(Level), 32'd0);
      chk("rst_pressed_state", 32'(State), 32'd0);
      chk("rst_pressed_pulse", 32'(Pulse), 32'd0);
      @(negedge clk) key = 1'b1;
      @(negedge clk) rst_n = 1'b1;
      wait_edges(10);
      chk("rst_idle_level", 32'(Level), 32'd0);

      // Long hold: key low for edges 0..44, high from edge 45.
      for (int e = 0; e < 60; e++) begin
         @(negedge clk);
         key = (e < 45) ? 1'b0 : 1'b1;
         @(posedge clk);
         #1;
         if (Pulse === 1'b1) pe.push_back(e);
      end
      chk("hold_pulse_count", 32'(pe.size()), 32'($size(exp_e)));
      for (int i = 0; i < $size(exp_e); i++) begin
         if (i < pe.size()) chk("hold_pulse_edge", 32'(pe[i]), 32'(exp_e[i]));
      end
      chk("hold_final_level", 32'(Level), 32'd0);
      chk("hold_final_state", 32'(State), 32'd0);

      wait_edges(2);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
